// File: rtl/l2_amo_seq_pkg.sv
// ============================================================================
//  Module      : l2_amo_seq_pkg
//  Description : Shared L2 AMO definitions: ALU opcodes, operand size codes,
//                sequencer state encoding and the size/alignment check.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package l2_amo_seq_pkg;

    // Field widths of the AMO opcode and the message data-size code
    localparam int c_amo_op_w = 4;
    localparam int c_size_w   = 3;

    // L2 AMO ALU opcodes
    localparam logic [c_amo_op_w-1:0] c_amo_op_nop  = 4'd0;
    localparam logic [c_amo_op_w-1:0] c_amo_op_lr   = 4'd1;
    localparam logic [c_amo_op_w-1:0] c_amo_op_sc   = 4'd2;
    localparam logic [c_amo_op_w-1:0] c_amo_op_swap = 4'd3;
    localparam logic [c_amo_op_w-1:0] c_amo_op_add  = 4'd4;
    localparam logic [c_amo_op_w-1:0] c_amo_op_and  = 4'd5;
    localparam logic [c_amo_op_w-1:0] c_amo_op_or   = 4'd6;
    localparam logic [c_amo_op_w-1:0] c_amo_op_xor  = 4'd7;
    localparam logic [c_amo_op_w-1:0] c_amo_op_max  = 4'd8;
    localparam logic [c_amo_op_w-1:0] c_amo_op_maxu = 4'd9;
    localparam logic [c_amo_op_w-1:0] c_amo_op_min  = 4'd10;
    localparam logic [c_amo_op_w-1:0] c_amo_op_minu = 4'd11;

    // Message data-size codes; only 1B..8B are legal AMO operand sizes
    localparam logic [c_size_w-1:0] c_size_0b  = 3'd0;
    localparam logic [c_size_w-1:0] c_size_1b  = 3'd1;
    localparam logic [c_size_w-1:0] c_size_2b  = 3'd2;
    localparam logic [c_size_w-1:0] c_size_4b  = 3'd3;
    localparam logic [c_size_w-1:0] c_size_8b  = 3'd4;
    localparam logic [c_size_w-1:0] c_size_16b = 3'd5;

    // Sequencer states, binary encoded
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_ALU_S1  = 3'd3,
        ST_ALU_S2  = 3'd4,
        ST_WR      = 3'd5,
        ST_RSP     = 3'd6
    } amo_state_t;

    // Operand must be 1/2/4/8 bytes and naturally aligned to its size
    function automatic logic amo_size_legal(input logic [c_size_w-1:0] size,
                                            input logic [2:0]          addr_lo);
        logic ok;
        case (size)
            c_size_1b: ok = 1'b1;
            c_size_2b: ok = (addr_lo[0] == 1'b0);
            c_size_4b: ok = (addr_lo[1:0] == 2'b00);
            c_size_8b: ok = (addr_lo == 3'b000);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/l2_amo_seq_if.sv
// ============================================================================
//  Module      : l2_amo_seq_if
//  Description : Request, data-array, AMO ALU and response signals of the
//                L2 AMO sequencer. master = sequencer, slave = surrounding L2.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface l2_amo_seq_if #(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 40
);
    // Request from the AMO issue point
    logic                                   req_val;
    logic                                   req_rdy;
    logic [l2_amo_seq_pkg::c_amo_op_w-1:0]  req_op;
    logic [ADDR_W-1:0]                      req_addr;
    logic [l2_amo_seq_pkg::c_size_w-1:0]    req_size;
    logic [LINE_W-1:0]                      req_data;

    // Data-array read port
    logic                                   rd_val;
    logic                                   rd_rdy;
    logic [ADDR_W-1:0]                      rd_addr;
    logic                                   rd_data_val;
    logic [LINE_W-1:0]                      rd_data;

    // Two-stage AMO ALU
    logic [l2_amo_seq_pkg::c_amo_op_w-1:0]  alu_op;
    logic [ADDR_W-1:0]                      alu_addr;
    logic [l2_amo_seq_pkg::c_size_w-1:0]    alu_size;
    logic [LINE_W-1:0]                      alu_mem;
    logic [LINE_W-1:0]                      alu_cpu;
    logic                                   alu_stall;
    logic [LINE_W-1:0]                      alu_result;

    // Data-array write port
    logic                                   wr_val;
    logic                                   wr_rdy;
    logic [ADDR_W-1:0]                      wr_addr;
    logic [LINE_W-1:0]                      wr_data;

    // Response to the requester
    logic                                   rsp_val;
    logic                                   rsp_rdy;
    logic [LINE_W-1:0]                      rsp_data;
    logic                                   rsp_err;

    logic                                   busy;

    modport master (
        input  req_val, req_op, req_addr, req_size, req_data,
        input  rd_rdy, rd_data_val, rd_data,
        input  alu_result,
        input  wr_rdy,
        input  rsp_rdy,
        output req_rdy,
        output rd_val, rd_addr,
        output alu_op, alu_addr, alu_size, alu_mem, alu_cpu, alu_stall,
        output wr_val, wr_addr, wr_data,
        output rsp_val, rsp_data, rsp_err,
        output busy
    );

    modport slave (
        output req_val, req_op, req_addr, req_size, req_data,
        output rd_rdy, rd_data_val, rd_data,
        output alu_result,
        output wr_rdy,
        output rsp_rdy,
        input  req_rdy,
        input  rd_val, rd_addr,
        input  alu_op, alu_addr, alu_size, alu_mem, alu_cpu, alu_stall,
        input  wr_val, wr_addr, wr_data,
        input  rsp_val, rsp_data, rsp_err,
        input  busy
    );

endinterface

`default_nettype wire

// File: rtl/l2_amo_seq_chk.sv
// ============================================================================
//  Module      : l2_amo_seq_chk
//  Description : Combinational AMO operand size / natural-alignment check.
//                Shared with the L2 decoder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module l2_amo_seq_chk
    import l2_amo_seq_pkg::*;
(
    input  wire logic [c_size_w-1:0] size,
    input  wire logic [2:0]          addr_lo,
    output logic                     legal
);

    // Pure function of the request fields; no state
    assign legal = amo_size_legal(size, addr_lo);

endmodule

`default_nettype wire

// File: rtl/l2_amo_seq.sv
// ============================================================================
//  Module      : l2_amo_seq
//  Description : Single in-flight L2 AMO read-modify-write sequencer.
//                Reads the target line, steps the two-stage AMO ALU via
//                alu_stall, writes the merged line back and returns the old
//                line. Optional feature macro: L2_AMO_SEQ_PERF_CNT_EN adds a
//                saturating 32-bit count of successful AMOs (perf_amo_cnt).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module l2_amo_seq
    import l2_amo_seq_pkg::*;
#(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 40
) (
    input  wire logic         clk,
    input  wire logic         rst,
    l2_amo_seq_if.master      bus
`ifdef L2_AMO_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       perf_amo_cnt
`endif
);

    // Number of byte-offset bits within one data-array line
    localparam int c_off_w = $clog2(LINE_W / 8);

    amo_state_t              r_state;
    amo_state_t              w_next;

    logic [c_amo_op_w-1:0]   r_op;
    logic [ADDR_W-1:0]       r_addr;
    logic [c_size_w-1:0]     r_size;
    logic [LINE_W-1:0]       r_cpu;
    logic [LINE_W-1:0]       r_old;
    logic [LINE_W-1:0]       r_wr_data;
    logic                    r_err;

    logic                    w_req_rdy;
    logic                    w_accept;
    logic                    w_legal;
    logic                    w_rd_val;
    logic                    w_wr_val;
    logic                    w_rsp_val;
    logic                    w_alu_stall;
    logic [ADDR_W-1:0]       w_line_addr;

    l2_amo_seq_chk u_chk (
        .size    (bus.req_size),
        .addr_lo (bus.req_addr[2:0]),
        .legal   (w_legal)
    );

    // Ready is forced low while reset is asserted, not just after it
    assign w_req_rdy   = !rst && (r_state == ST_IDLE);
    assign w_accept    = bus.req_val && w_req_rdy;
    assign w_line_addr = {r_addr[ADDR_W-1:c_off_w], {c_off_w{1'b0}}};

    // State register; async reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded handshake/stall outputs
    always_comb begin
        w_next      = r_state;
        w_rd_val    = 1'b0;
        w_wr_val    = 1'b0;
        w_rsp_val   = 1'b0;
        w_alu_stall = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = w_legal ? ST_RD_REQ : ST_RSP;
                end
            end
            ST_RD_REQ: begin
                w_rd_val = 1'b1;
                if (bus.rd_rdy) begin
                    w_next = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (bus.rd_data_val) begin
                    w_next = ST_ALU_S1;
                end
            end
            ST_ALU_S1: begin
                // Single-cycle enable of the ALU stage-1 flops
                w_alu_stall = 1'b0;
                w_next      = ST_ALU_S2;
            end
            ST_ALU_S2: begin
                w_next = (r_op == c_amo_op_nop) ? ST_RSP : ST_WR;
            end
            ST_WR: begin
                w_wr_val = 1'b1;
                if (bus.wr_rdy) begin
                    w_next = ST_RSP;
                end
            end
            ST_RSP: begin
                w_rsp_val = 1'b1;
                if (bus.rsp_rdy) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request latches, old-line capture and write-data capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= '0;
            r_addr    <= '0;
            r_size    <= '0;
            r_cpu     <= '0;
            r_old     <= '0;
            r_wr_data <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op   <= bus.req_op;
                r_addr <= bus.req_addr;
                r_size <= bus.req_size;
                r_cpu  <= bus.req_data;
                r_err  <= !w_legal;
                // Cleared so a rejected request returns an all-zero line
                r_old  <= '0;
            end
            // Read data outside RD_WAIT is stray and dropped
            if ((r_state == ST_RD_WAIT) && bus.rd_data_val) begin
                r_old <= bus.rd_data;
            end
            if (r_state == ST_ALU_S2) begin
                r_wr_data <= bus.alu_result;
            end
        end
    end

`ifdef L2_AMO_SEQ_PERF_CNT_EN
    // Saturating count of responses that completed without error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_amo_cnt <= '0;
        end else if (w_rsp_val && bus.rsp_rdy && !r_err && (perf_amo_cnt != 32'hFFFF_FFFF)) begin
            perf_amo_cnt <= perf_amo_cnt + 32'd1;
        end
    end
`endif

    assign bus.req_rdy   = w_req_rdy;

    assign bus.rd_val    = w_rd_val;
    assign bus.rd_addr   = w_line_addr;

    assign bus.alu_op    = r_op;
    assign bus.alu_addr  = r_addr;
    assign bus.alu_size  = r_size;
    assign bus.alu_mem   = r_old;
    assign bus.alu_cpu   = r_cpu;
    assign bus.alu_stall = w_alu_stall;

    assign bus.wr_val    = w_wr_val;
    assign bus.wr_addr   = w_line_addr;
    assign bus.wr_data   = r_wr_data;

    assign bus.rsp_val   = w_rsp_val;
    assign bus.rsp_data  = r_old;
    assign bus.rsp_err   = r_err;

    assign bus.busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_l2_amo_seq.sv
// ============================================================================
//  Module      : tb_l2_amo_seq
//  Description : Directed self-checking bench for l2_amo_seq. Acts as request
//                source, data-array port, AMO ALU and response sink.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_l2_amo_seq;
    import l2_amo_seq_pkg::*;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 40;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    l2_amo_seq_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

`ifdef L2_AMO_SEQ_PERF_CNT_EN
    logic [31:0] perf_amo_cnt;
`endif

    l2_amo_seq #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef L2_AMO_SEQ_PERF_CNT_EN
        ,
        .perf_amo_cnt (perf_amo_cnt)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;
    int exp_perf = 0;

    // Observations of the most recent transaction
    int                obs_rsp_t, obs_wait, obs_rd_cnt, obs_wr_cnt;
    int                obs_stall_cnt, obs_unstable, obs_rdy_busy;
    logic              obs_done, obs_hs_rdy, obs_rsp_err;
    logic              obs_abort_wr_val, obs_abort_busy;
    logic [LINE_W-1:0] obs_rsp_data, obs_wr_data;
    logic [ADDR_W-1:0] obs_rd_addr, obs_wr_addr;

    // Reference two-stage ALU: updates the addressed lane of the memory line
    function automatic logic [LINE_W-1:0] alu_model(input logic [3:0] op,
            input logic [ADDR_W-1:0] addr, input logic [2:0] size,
            input logic [LINE_W-1:0] mem, input logic [LINE_W-1:0] cpu);
        logic [LINE_W-1:0] res;
        logic [63:0] a, b, r;
        int nb, off;
        res = mem;
        a = '0;
        b = '0;
        nb = (size == c_size_1b) ? 1 : (size == c_size_2b) ? 2 : (size == c_size_4b) ? 4 : 8;
        off = int'(addr[3:0]);
        for (int i = 0; i < nb; i++) begin
            a[8*i +: 8] = mem[8*(off+i) +: 8];
            b[8*i +: 8] = cpu[8*(off+i) +: 8];
        end
        case (op)
            c_amo_op_add:  r = a + b;
            c_amo_op_maxu: r = (a > b) ? a : b;
            default:       r = a;
        endcase
        for (int i = 0; i < nb; i++) begin
            res[8*(off+i) +: 8] = r[8*i +: 8];
        end
        return res;
    endfunction

    // Issue one request and service it cycle by cycle; t counts cycles after accept
    task automatic run_amo(input logic [3:0] op, input logic [ADDR_W-1:0] addr,
            input logic [2:0] size, input logic [LINE_W-1:0] cpu,
            input logic [LINE_W-1:0] mem, input int rd_hold, input int wr_hold,
            input int rsp_hold, input bit abort_wr, input bit b2b);
        int t, rd_seen, wr_seen, rsp_seen;
        bit rd_fire, fin;
        obs_rsp_t = -1; obs_wait = 0; obs_rd_cnt = 0; obs_wr_cnt = 0;
        obs_stall_cnt = 0; obs_unstable = 0; obs_rdy_busy = 0;
        obs_done = 1'b0; obs_hs_rdy = 1'b1; obs_rsp_err = 1'b0;
        obs_abort_wr_val = 1'b1; obs_abort_busy = 1'b1;
        obs_rsp_data = '0; obs_wr_data = '0; obs_rd_addr = '0; obs_wr_addr = '0;
        bus.req_op = op; bus.req_addr = addr; bus.req_size = size; bus.req_data = cpu;
        bus.req_val = 1'b1;
        while (!bus.req_rdy && obs_wait < 20) begin
            @(posedge clk); #1;
            obs_wait++;
        end
        if (!bus.req_rdy) begin
            bus.req_val = 1'b0;
            return;
        end
        t = 0; rd_seen = 0; wr_seen = 0; rsp_seen = 0; rd_fire = 1'b0; fin = 1'b0;
        while (!fin && t < 60) begin
            @(posedge clk); #1;
            t++;
            bus.req_val     = 1'b0;
            bus.rd_data_val = rd_fire;
            bus.rd_data     = rd_fire ? mem : '0;
            rd_fire         = 1'b0;
            if (abort_wr && bus.wr_val) begin
                rst = 1'b1;
                #1;
                obs_abort_wr_val = bus.wr_val;
                obs_abort_busy   = bus.busy;
                fin = 1'b1;
            end else begin
                if (bus.busy && bus.req_rdy) obs_rdy_busy++;
                if (!bus.alu_stall) begin
                    obs_stall_cnt++;
                    bus.alu_result = alu_model(bus.alu_op, bus.alu_addr, bus.alu_size,
                                               bus.alu_mem, bus.alu_cpu);
                end
                if (bus.rd_val) begin
                    if (rd_seen == 0) obs_rd_addr = bus.rd_addr;
                    else if (bus.rd_addr !== obs_rd_addr) obs_unstable++;
                    rd_seen++;
                    bus.rd_rdy = (rd_seen > rd_hold);
                    rd_fire = bus.rd_rdy;
                    if (bus.rd_rdy) obs_rd_cnt++;
                end else begin
                    bus.rd_rdy = 1'b0;
                end
                if (bus.wr_val) begin
                    if (wr_seen == 0) begin
                        obs_wr_addr = bus.wr_addr;
                        obs_wr_data = bus.wr_data;
                    end else if (bus.wr_addr !== obs_wr_addr || bus.wr_data !== obs_wr_data) begin
                        obs_unstable++;
                    end
                    wr_seen++;
                    bus.wr_rdy = (wr_seen > wr_hold);
                    if (bus.wr_rdy) obs_wr_cnt++;
                end else begin
                    bus.wr_rdy = 1'b0;
                end
                if (bus.rsp_val) begin
                    if (rsp_seen == 0) begin
                        obs_rsp_t    = t;
                        obs_rsp_data = bus.rsp_data;
                        obs_rsp_err  = bus.rsp_err;
                    end else if (bus.rsp_data !== obs_rsp_data || bus.rsp_err !== obs_rsp_err) begin
                        obs_unstable++;
                    end
                    rsp_seen++;
                    bus.rsp_rdy = (rsp_seen > rsp_hold);
                    if (bus.rsp_rdy) begin
                        fin = 1'b1;
                        obs_hs_rdy = bus.req_rdy;
                        if (b2b) bus.req_val = 1'b1;
                    end
                end else begin
                    bus.rsp_rdy = 1'b0;
                end
            end
        end
        if (!abort_wr) begin
            @(posedge clk); #1;
            bus.rsp_rdy = 1'b0; bus.rd_rdy = 1'b0; bus.wr_rdy = 1'b0; bus.rd_data_val = 1'b0;
        end
        obs_done = fin;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (bus.req_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_req_rdy: got %b want 0", bus.req_rdy); end
        n_vec++; if (bus.alu_stall !== 1'b1) begin n_bad++; $display("FAIL reset_alu_stall: got %b want 1", bus.alu_stall); end
        n_vec++; if ({bus.rd_val, bus.wr_val, bus.rsp_val, bus.busy, bus.rsp_err} !== 5'b0) begin
            n_bad++; $display("FAIL reset_valids: got %b want 00000", {bus.rd_val, bus.wr_val, bus.rsp_val, bus.busy, bus.rsp_err}); end
        n_vec++; if (bus.rsp_data !== '0) begin n_bad++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (bus.req_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_release_rdy: got %b want 1", bus.req_rdy); end
    endtask

    task automatic test_add_8b();
        logic [LINE_W-1:0] mem, cpu, exp_wr;
        mem    = {64'd5, 64'hAAAA_BBBB_CCCC_DDDD};
        cpu    = {64'd3, 64'h1111_1111_1111_1111};
        exp_wr = {64'd8, 64'hAAAA_BBBB_CCCC_DDDD};
        run_amo(c_amo_op_add, 40'h08, c_size_8b, cpu, mem, 0, 0, 0, 1'b0, 1'b0);
        exp_perf++;
        n_vec++; if (obs_done !== 1'b1) begin n_bad++; $display("FAIL add8_done: got %b want 1", obs_done); end
        n_vec++; if (obs_rsp_t !== 6) begin n_bad++; $display("FAIL add8_latency: got %0d want 6", obs_rsp_t); end
        n_vec++; if (obs_wr_data !== exp_wr) begin n_bad++; $display("FAIL add8_wr_data: got %h want %h", obs_wr_data, exp_wr); end
        n_vec++; if (obs_rsp_data !== mem) begin n_bad++; $display("FAIL add8_rsp_data: got %h want %h", obs_rsp_data, mem); end
        n_vec++; if (obs_rsp_err !== 1'b0) begin n_bad++; $display("FAIL add8_rsp_err: got %b want 0", obs_rsp_err); end
        n_vec++; if (obs_wr_cnt !== 1) begin n_bad++; $display("FAIL add8_wr_cnt: got %0d want 1", obs_wr_cnt); end
        n_vec++; if (obs_stall_cnt !== 1) begin n_bad++; $display("FAIL add8_stall_cycles: got %0d want 1", obs_stall_cnt); end
        n_vec++; if (obs_rd_addr !== 40'h0) begin n_bad++; $display("FAIL add8_rd_addr: got %h want 0", obs_rd_addr); end
    endtask

    task automatic test_maxu_4b();
        logic [LINE_W-1:0] mem, cpu, exp_wr;
        mem    = 128'h0123_4567_89AB_CDEF_0000_0001_DEAD_BEEF;
        cpu    = 128'h0000_0000_0000_0000_FFFF_FFFF_0000_0000;
        exp_wr = 128'h0123_4567_89AB_CDEF_FFFF_FFFF_DEAD_BEEF;
        run_amo(c_amo_op_maxu, 40'h04, c_size_4b, cpu, mem, 0, 0, 0, 1'b0, 1'b0);
        exp_perf++;
        n_vec++; if (obs_wr_data !== exp_wr) begin n_bad++; $display("FAIL maxu4_wr_data: got %h want %h", obs_wr_data, exp_wr); end
        n_vec++; if (obs_rsp_data !== mem) begin n_bad++; $display("FAIL maxu4_rsp_data: got %h want %h", obs_rsp_data, mem); end
        n_vec++; if (obs_rsp_t !== 6) begin n_bad++; $display("FAIL maxu4_latency: got %0d want 6", obs_rsp_t); end
    endtask

    task automatic test_nop();
        logic [LINE_W-1:0] mem;
        mem = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
        run_amo(c_amo_op_nop, 40'h03, c_size_1b, 128'h0, mem, 0, 0, 0, 1'b0, 1'b0);
        exp_perf++;
        n_vec++; if (obs_wr_cnt !== 0) begin n_bad++; $display("FAIL nop_wr_cnt: got %0d want 0", obs_wr_cnt); end
        n_vec++; if (obs_rsp_t !== 5) begin n_bad++; $display("FAIL nop_latency: got %0d want 5", obs_rsp_t); end
        n_vec++; if (obs_rsp_data !== mem) begin n_bad++; $display("FAIL nop_rsp_data: got %h want %h", obs_rsp_data, mem); end
    endtask

    task automatic test_illegal();
        logic [2:0]        sizes [5] = '{c_size_4b, c_size_8b, c_size_2b, c_size_16b, c_size_0b};
        logic [ADDR_W-1:0] addrs [5] = '{40'h02, 40'h04, 40'h01, 40'h00, 40'h00};
        for (int k = 0; k < 5; k++) begin
            run_amo(c_amo_op_add, addrs[k], sizes[k], {4{32'h1234_5678}}, {4{32'hCAFE_F00D}},
                    0, 0, 0, 1'b0, 1'b0);
            n_vec++; if (obs_rsp_t !== 1 || obs_rsp_err !== 1'b1) begin
                n_bad++; $display("FAIL illegal%0d_rsp: got t=%0d err=%b want t=1 err=1", k, obs_rsp_t, obs_rsp_err); end
            n_vec++; if (obs_rsp_data !== '0) begin n_bad++; $display("FAIL illegal%0d_rsp_data: got %h want 0", k, obs_rsp_data); end
            n_vec++; if (obs_rd_cnt !== 0 || obs_wr_cnt !== 0) begin
                n_bad++; $display("FAIL illegal%0d_array: got rd=%0d wr=%0d want 0 0", k, obs_rd_cnt, obs_wr_cnt); end
        end
    endtask

    task automatic test_stall_hold();
        logic [LINE_W-1:0] mem, cpu, exp_wr;
        mem    = 128'h1111_2222_00FF_3333_4444_5555_6666_7777;
        cpu    = 128'hFFFF_FFFF_0102_FFFF_FFFF_FFFF_FFFF_FFFF;
        exp_wr = 128'h1111_2222_0201_3333_4444_5555_6666_7777;
        run_amo(c_amo_op_add, 40'h12_3456_780A, c_size_2b, cpu, mem, 3, 2, 4, 1'b0, 1'b0);
        exp_perf++;
        n_vec++; if (obs_unstable !== 0) begin n_bad++; $display("FAIL hold_stability: got %0d changes want 0", obs_unstable); end
        n_vec++; if (obs_rdy_busy !== 0) begin n_bad++; $display("FAIL hold_req_rdy: got %0d busy-ready cycles want 0", obs_rdy_busy); end
        n_vec++; if (obs_rsp_t !== 11) begin n_bad++; $display("FAIL hold_latency: got %0d want 11", obs_rsp_t); end
        n_vec++; if (obs_rd_addr !== 40'h12_3456_7800 || obs_wr_addr !== 40'h12_3456_7800) begin
            n_bad++; $display("FAIL hold_line_addr: got rd=%h wr=%h want 1234567800", obs_rd_addr, obs_wr_addr); end
        n_vec++; if (obs_wr_data !== exp_wr) begin n_bad++; $display("FAIL hold_wr_data: got %h want %h", obs_wr_data, exp_wr); end
        n_vec++; if (obs_rsp_data !== mem) begin n_bad++; $display("FAIL hold_rsp_data: got %h want %h", obs_rsp_data, mem); end
    endtask

    task automatic test_back_to_back();
        logic [LINE_W-1:0] mem, cpu, exp_wr;
        logic hs_rdy_first;
        mem    = {64'hFFFF_0000_FFFF_0000, 64'h0000_0000_0000_00FF};
        cpu    = {64'h0, 64'h1};
        exp_wr = {64'hFFFF_0000_FFFF_0000, 64'h0000_0000_0000_0100};
        run_amo(c_amo_op_add, 40'h10, c_size_8b, cpu, mem, 0, 0, 0, 1'b0, 1'b1);
        exp_perf++;
        hs_rdy_first = obs_hs_rdy;
        n_vec++; if (hs_rdy_first !== 1'b0) begin n_bad++; $display("FAIL b2b_rdy_in_rsp: got %b want 0", hs_rdy_first); end
        run_amo(c_amo_op_add, 40'h10, c_size_8b, cpu, mem, 0, 0, 0, 1'b0, 1'b0);
        exp_perf++;
        n_vec++; if (obs_wait !== 0) begin n_bad++; $display("FAIL b2b_accept_wait: got %0d want 0", obs_wait); end
        n_vec++; if (obs_rsp_t !== 6) begin n_bad++; $display("FAIL b2b_latency: got %0d want 6", obs_rsp_t); end
        n_vec++; if (obs_wr_data !== exp_wr) begin n_bad++; $display("FAIL b2b_wr_data: got %h want %h", obs_wr_data, exp_wr); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] perf_before;
        perf_before = 32'(exp_perf);
        run_amo(c_amo_op_add, 40'h08, c_size_8b, {64'd3, 64'd0}, {64'd5, 64'd0}, 0, 100, 0, 1'b1, 1'b0);
        n_vec++; if (obs_done !== 1'b1) begin n_bad++; $display("FAIL abort_reached_wr: got %b want 1", obs_done); end
        n_vec++; if (obs_abort_wr_val !== 1'b0 || obs_abort_busy !== 1'b0) begin
            n_bad++; $display("FAIL abort_wr_drop: got wr_val=%b busy=%b want 0 0", obs_abort_wr_val, obs_abort_busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_vec++; if (bus.req_rdy !== 1'b1 || bus.rsp_val !== 1'b0 || bus.wr_val !== 1'b0) begin
                n_bad++; $display("FAIL abort_after_%0d: got rdy=%b rsp=%b wr=%b want 1 0 0", c, bus.req_rdy, bus.rsp_val, bus.wr_val); end
        end
`ifdef L2_AMO_SEQ_PERF_CNT_EN
        n_vec++; if (perf_amo_cnt !== 32'd0) begin
            n_bad++; $display("FAIL abort_perf_cnt: got %0d want 0 (was %0d before reset)", perf_amo_cnt, perf_before); end
`else
        perf_before = 32'd0;
`endif
    endtask

    task automatic test_perf_cnt();
`ifdef L2_AMO_SEQ_PERF_CNT_EN
        n_vec++; if (perf_amo_cnt !== 32'(exp_perf)) begin
            n_bad++; $display("FAIL perf_cnt: got %0d want %0d", perf_amo_cnt, exp_perf); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        bus.req_val = 1'b0; bus.req_op = '0; bus.req_addr = '0; bus.req_size = '0; bus.req_data = '0;
        bus.rd_rdy = 1'b0; bus.rd_data_val = 1'b0; bus.rd_data = '0;
        bus.alu_result = '0; bus.wr_rdy = 1'b0; bus.rsp_rdy = 1'b0;
        test_reset();
        test_add_8b();
        test_maxu_4b();
        test_nop();
        test_illegal();
        test_stall_hold();
        test_back_to_back();
        test_perf_cnt();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200us want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
